// File: rtl/mips_mem_responder.sv
// ---------------------------------------------------------------------------
// mips_mem_responder
//   Boot-loaded, word-addressed memory serving the MIPS fetch and data ports.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mips_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           PC,
  output logic [31:0]           Instruction,
  input  logic [31:0]           Address,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [31:0]           Write_data,
  output logic [31:0]           Read_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [31:0]           ld_data,
  input  logic                  ld_last,
  output logic                  cpu_rst,
  output logic                  err_misalign,
  output logic                  err_range,
  output logic [31:0]           err_addr,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [CNT_WIDTH-1:0]  wr_count
);

  localparam int c_DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_HOLD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_mem [0:c_DEPTH-1];

  logic                  w_run;
  logic                  w_pc_ok;
  logic [ADDR_WIDTH-1:0] w_pc_idx;
  logic                  w_d_mis;
  logic                  w_d_oor;
  logic                  w_d_legal;
  logic [ADDR_WIDTH-1:0] w_d_idx;
  logic                  w_rd_ok;
  logic                  w_wr_ok;
  logic                  w_d_err;
  logic                  w_f_err;
  logic                  w_unused;

  assign w_run     = (r_state == S_RUN);
  assign w_pc_ok   = (PC[31:ADDR_WIDTH+2] == '0);
  assign w_pc_idx  = PC[ADDR_WIDTH+1:2];
  assign w_d_mis   = (Address[1:0] != 2'b00);
  assign w_d_oor   = (Address[31:ADDR_WIDTH+2] != '0);
  assign w_d_legal = !w_d_mis && !w_d_oor;
  assign w_d_idx   = Address[ADDR_WIDTH+1:2];
  assign w_rd_ok   = w_run && MemRead && w_d_legal;
  assign w_wr_ok   = w_run && MemWrite && w_d_legal;
  assign w_d_err   = w_run && (MemRead || MemWrite) && !w_d_legal;
  assign w_f_err   = w_run && !w_pc_ok;
  assign w_unused  = ^PC[1:0];

  // Core reset and loader ready decode straight from state, so an async
  // rst assertion raises cpu_rst without waiting for a clock edge.
  assign cpu_rst  = (r_state != S_RUN);
  assign ld_ready = (r_state == S_LOAD);

  assign Instruction = w_pc_ok ? r_mem[w_pc_idx] : 32'd0;
  assign Read_data   = w_rd_ok ? r_mem[w_d_idx]  : 32'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_LOAD;
    end else begin
      case (r_state)
        S_LOAD:  if (ld_valid && ld_last) r_state <= S_HOLD;
        S_HOLD:  r_state <= S_RUN;
        S_RUN:   r_state <= S_RUN;
        default: r_state <= S_LOAD;
      endcase
    end
  end

  // Array contents deliberately survive reset; rst only gates writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      if ((r_state == S_LOAD) && ld_valid)
        r_mem[ld_addr] <= ld_data;
      else if (w_wr_ok)
        r_mem[w_d_idx] <= Write_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_misalign <= 1'b0;
      err_range    <= 1'b0;
      err_addr     <= 32'd0;
    end else begin
      if (w_d_err) begin
        err_misalign <= err_misalign | w_d_mis;
        err_range    <= err_range | w_d_oor;
      end
      if (w_f_err)
        err_range <= 1'b1;
      // Only the first offending address is kept; data beats fetch.
      if (!err_misalign && !err_range) begin
        if (w_d_err)
          err_addr <= Address;
        else if (w_f_err)
          err_addr <= PC;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (w_rd_ok && (rd_count != '1))
        rd_count <= rd_count + 1'b1;
      if (w_wr_ok && (wr_count != '1))
        wr_count <= wr_count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mips_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mips_mem_responder
//   Scoreboard bench: boot load, data read/write, errors and mid-run reset.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mips_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic [31:0] Address;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Write_data;
  logic [31:0] Read_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        cpu_rst;
  logic        err_misalign;
  logic        err_range;
  logic [31:0] err_addr;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_rd   = 0;
  int          exp_wr   = 0;
  logic [31:0] model [1024];
  logic [31:0] exp_q [$];

  mips_mem_responder #(.ADDR_WIDTH(10), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .PC(PC), .Instruction(Instruction),
    .Address(Address), .MemRead(MemRead), .MemWrite(MemWrite),
    .Write_data(Write_data), .Read_data(Read_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_last(ld_last), .cpu_rst(cpu_rst),
    .err_misalign(err_misalign), .err_range(err_range), .err_addr(err_addr),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_rd"}, 32'(rd_count), 32'(exp_rd));
    check({tag, "_wr"}, 32'(wr_count), 32'(exp_wr));
  endtask

  task automatic load_word(input logic [9:0] idx, input logic [31:0] data, input logic last);
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = idx; ld_data = data; ld_last = last;
    #1;
    check("ld_ready_load", 32'(ld_ready), 32'd1);
    check("cpu_rst_load", 32'(cpu_rst), 32'd1);
    @(posedge clk);
    model[idx] = data;
    #1 ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic hold_to_run();
    @(negedge clk);
    check("cpu_rst_hold", 32'(cpu_rst), 32'd1);
    check("ld_ready_hold", 32'(ld_ready), 32'd0);
    @(posedge clk); #1;
    check("cpu_rst_run", 32'(cpu_rst), 32'd0);
  endtask

  task automatic data_op(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    logic legal;
    @(negedge clk);
    MemRead = rd; MemWrite = wr; Address = addr; Write_data = wdata;
    legal = (addr[1:0] == 2'b00) && (addr[31:12] == 20'd0);
    if (rd) exp_q.push_back(legal ? model[addr[11:2]] : 32'd0);
    #1;
    if (rd) check("read_data", Read_data, exp_q.pop_front());
    @(posedge clk);
    if (legal) begin
      if (rd) exp_rd++;
      if (wr) begin model[addr[11:2]] = wdata; exp_wr++; end
    end
    #1 MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] exp);
    @(negedge clk);
    PC = pc;
    #1 check("instruction", Instruction, exp);
  endtask

  initial begin
    rst = 1'b0; PC = 32'd0; Address = 32'd0; MemRead = 1'b0; MemWrite = 1'b0;
    Write_data = 32'd0; ld_valid = 1'b0; ld_addr = '0; ld_data = 32'd0; ld_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_ld_ready", 32'(ld_ready), 32'd1);
    check("rst_err", {30'd0, err_misalign, err_range}, 32'd0);
    check("rst_err_addr", err_addr, 32'd0);
    check_counts("rst");
    @(negedge clk) rst = 1'b1;

    // Boot load
    load_word(10'd0, 32'h11, 1'b0);
    load_word(10'd1, 32'h22, 1'b0);
    load_word(10'd2, 32'h33, 1'b1);
    hold_to_run();
    fetch(32'h8, 32'h33);
    fetch(32'h5, 32'h22);

    // Loader ignored in RUN
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = 10'd0; ld_data = 32'hFF; ld_last = 1'b1;
    @(posedge clk); #1 ld_valid = 1'b0; ld_last = 1'b0;
    fetch(32'h0, 32'h11);
    check("ld_ready_run", 32'(ld_ready), 32'd0);

    // Data read/write
    data_op(1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
    data_op(1'b1, 1'b0, 32'h40, 32'h0);
    check_counts("rw");
    data_op(1'b0, 1'b1, 32'h44, 32'h77);

    // Misalignment: first address captured, no array change
    data_op(1'b0, 1'b1, 32'h42, 32'h12345678);
    data_op(1'b1, 1'b0, 32'h45, 32'h0);
    check("mis_flag", 32'(err_misalign), 32'd1);
    check("mis_range", 32'(err_range), 32'd0);
    check("mis_addr", err_addr, 32'h42);
    check_counts("mis");
    data_op(1'b1, 1'b0, 32'h40, 32'h0);

    // Out of range
    data_op(1'b1, 1'b0, 32'h1000, 32'h0);
    check("range_flag", 32'(err_range), 32'd1);
    check("range_addr_kept", err_addr, 32'h42);
    fetch(32'h2000, 32'h0);
    PC = 32'h0;

    // Simultaneous read and write of one word
    data_op(1'b1, 1'b1, 32'h40, 32'h5);
    data_op(1'b1, 1'b0, 32'h40, 32'h0);
    check_counts("simul");

    // Mid-run reset with an in-flight write
    @(negedge clk);
    MemWrite = 1'b1; Address = 32'h44; Write_data = 32'h99; rst = 1'b0;
    #1;
    check("mrst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("mrst_ld_ready", 32'(ld_ready), 32'd1);
    check("mrst_err", {30'd0, err_misalign, err_range}, 32'd0);
    check("mrst_err_addr", err_addr, 32'd0);
    exp_rd = 0; exp_wr = 0;
    check_counts("mrst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; MemWrite = 1'b0;
    load_word(10'd3, 32'hAB, 1'b1);
    hold_to_run();
    data_op(1'b1, 1'b0, 32'h40, 32'h0);
    data_op(1'b1, 1'b0, 32'h44, 32'h0);
    fetch(32'hC, 32'hAB);

    // Out-of-range fetch with no prior error captures PC
    fetch(32'h2000, 32'h0);
    @(posedge clk); #1;
    check("fetch_err_range", 32'(err_range), 32'd1);
    check("fetch_err_mis", 32'(err_misalign), 32'd0);
    check("fetch_err_addr", err_addr, 32'h2000);
    PC = 32'h0;
    check_counts("final");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
